// File: rtl/ppu_regs_pkg.sv
// ppu_regs_pkg
// Shared types and constants for the PPU CPU-side VRAM access controller.
//   acc_state_e : access sequencer states (IDLE -> ADDR -> STRB -> INC -> IDLE)
//   pend_e      : queued/in-flight CPU access kind (NONE, RD, WR)
//   INC_SMALL / INC_LARGE : V post-increment amounts selected by I_1_32
package ppu_regs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        STRB = 2'd2,
        INC  = 2'd3
    } acc_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } pend_e;

    localparam int INC_SMALL = 1;
    localparam int INC_LARGE = 32;

endpackage

// File: rtl/ppu_loopy_regs.sv
// ppu_loopy_regs
// Scroll/address register file behind $2005/$2006: T, V, fine X and the
// shared first/second write toggle.
// Ports:
//   clk, n_res          : clock, asynchronous active-low reset
//   w5_pulse, w6_pulse  : one-CLK write pulses for $2005 / $2006
//   r2_pulse            : one-CLK $2002 read pulse (clears the toggle)
//   db                  : CPU data captured with the write pulse
//   inc_en, inc_amt     : post-access increment request and amount for V
//   t, v, fx, w_tgl     : register outputs
module ppu_loopy_regs (
    input  logic        clk,
    input  logic        n_res,
    input  logic        w5_pulse,
    input  logic        w6_pulse,
    input  logic        r2_pulse,
    input  logic [7:0]  db,
    input  logic        inc_en,
    input  logic [14:0] inc_amt,
    output logic [14:0] t,
    output logic [14:0] v,
    output logic [2:0]  fx,
    output logic        w_tgl
);

    logic [14:0] t_q, t_d;
    logic [14:0] v_q, v_d;
    logic [2:0]  fx_q, fx_d;
    logic        w_tgl_q, w_tgl_d;
    // Set by a $2006 second write; V picks up the new T one CLK later.
    logic        copy_q, copy_d;

    always_comb begin
        t_d     = t_q;
        v_d     = v_q;
        fx_d    = fx_q;
        w_tgl_d = w_tgl_q;
        copy_d  = 1'b0;

        if (w6_pulse) begin
            if (!w_tgl_q) begin
                t_d[13:8] = db[5:0];
                t_d[14]   = 1'b0;
                w_tgl_d   = 1'b1;
            end else begin
                t_d[7:0]  = db;
                w_tgl_d   = 1'b0;
                copy_d    = 1'b1;
            end
        end else if (w5_pulse) begin
            if (!w_tgl_q) begin
                t_d[4:0]  = db[7:3];
                fx_d      = db[2:0];
                w_tgl_d   = 1'b1;
            end else begin
                t_d[14:12] = db[2:0];
                t_d[9:5]   = db[7:3];
                w_tgl_d    = 1'b0;
            end
        end

        // A $2002 read in the same CLK overrides any toggle flip above.
        if (r2_pulse) begin
            w_tgl_d = 1'b0;
        end

        // The T->V copy takes precedence; a coincident increment is dropped.
        if (copy_q) begin
            v_d = t_q;
        end else if (inc_en) begin
            v_d = v_q + inc_amt;
        end
    end

    always_ff @(posedge clk or negedge n_res) begin
        if (!n_res) begin
            t_q     <= '0;
            v_q     <= '0;
            fx_q    <= '0;
            w_tgl_q <= 1'b0;
            copy_q  <= 1'b0;
        end else begin
            t_q     <= t_d;
            v_q     <= v_d;
            fx_q    <= fx_d;
            w_tgl_q <= w_tgl_d;
            copy_q  <= copy_d;
        end
    end

    assign t     = t_q;
    assign v     = v_q;
    assign fx    = fx_q;
    assign w_tgl = w_tgl_q;

endmodule

// File: rtl/ppu_vram_access_ctrl.sv
// ppu_vram_access_ctrl
// Sequences CPU $2007 accesses onto the PPU external bus and hosts the
// $2005/$2006 scroll registers (via ppu_loopy_regs).
// Ports:
//   CLK, n_RES                      : clock, asynchronous active-low reset
//   n_W5, n_W6, n_W7, n_R7, n_R2    : active-low register strobes (levels)
//   DB_in                           : CPU data bus
//   I_1_32                          : V increment select (0: +1, 1: +32)
//   REN_BUSY                        : renderer owns the external bus
//   VD_in                           : PPU data bus read value
//   VA, ALE, n_RD, n_WR             : PPU bus address / strobes
//   VD_out, VD_oe                   : write data and its drive enable
//   CPU_RDBUF                       : $2007 read buffer
//   T, V, FX, W_TGL                 : scroll registers and write toggle
//   CPU_BUSY                        : an access is queued or in flight
//   OVR                             : a queued access was replaced
module ppu_vram_access_ctrl #(
    parameter int VA_W      = 14,
    parameter int INC_SMALL = ppu_regs_pkg::INC_SMALL,
    parameter int INC_LARGE = ppu_regs_pkg::INC_LARGE
) (
    input  logic            CLK,
    input  logic            n_RES,
    input  logic            n_W5,
    input  logic            n_W6,
    input  logic            n_W7,
    input  logic            n_R7,
    input  logic            n_R2,
    input  logic [7:0]      DB_in,
    input  logic            I_1_32,
    input  logic            REN_BUSY,
    input  logic [7:0]      VD_in,
    output logic [VA_W-1:0] VA,
    output logic            ALE,
    output logic            n_RD,
    output logic            n_WR,
    output logic [7:0]      VD_out,
    output logic            VD_oe,
    output logic [7:0]      CPU_RDBUF,
    output logic [14:0]     T,
    output logic [14:0]     V,
    output logic [2:0]      FX,
    output logic            W_TGL,
    output logic            CPU_BUSY,
    output logic            OVR
);

    import ppu_regs_pkg::*;

    // Strobe bit order: {W5, W6, W7, R7, R2}
    logic [4:0]  strb_now;
    logic [4:0]  strb_prev_q, strb_prev_d;
    logic [4:0]  strb_pulse;

    acc_state_e  state_q, state_d;
    pend_e       pend_q, pend_d;   // queued, not yet started
    pend_e       op_q, op_d;       // access currently on the bus
    logic [7:0]  vd_out_q, vd_out_d;
    logic [7:0]  rdbuf_q, rdbuf_d;
    logic        ovr_q, ovr_d;

    logic        launch;
    logic        inc_en;
    logic [14:0] inc_amt;

    assign strb_now   = {n_W5, n_W6, n_W7, n_R7, n_R2};
    // Strobes act once: previous sample high, current sample low.
    assign strb_pulse = strb_prev_q & ~strb_now;
    assign strb_prev_d = strb_now;

    assign launch  = (state_q == IDLE) && (pend_q != NONE) && !REN_BUSY;
    assign inc_en  = (state_q == INC);
    assign inc_amt = I_1_32 ? 15'(INC_LARGE) : 15'(INC_SMALL);

    ppu_loopy_regs u_loopy (
        .clk      (CLK),
        .n_res    (n_RES),
        .w5_pulse (strb_pulse[4]),
        .w6_pulse (strb_pulse[3]),
        .r2_pulse (strb_pulse[0]),
        .db       (DB_in),
        .inc_en   (inc_en),
        .inc_amt  (inc_amt),
        .t        (T),
        .v        (V),
        .fx       (FX),
        .w_tgl    (W_TGL)
    );

    // ---- FSM: state register ----
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (launch) state_d = ADDR;
            ADDR:    state_d = STRB;
            STRB:    state_d = INC;
            INC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- FSM: outputs (Moore, so reset forces them at once) ----
    always_comb begin
        ALE      = (state_q == ADDR);
        n_RD     = !((state_q == STRB) && (op_q == RD));
        n_WR     = !((state_q == STRB) && (op_q == WR));
        VD_oe    = ((state_q == ADDR) || (state_q == STRB)) && (op_q == WR);
        VA       = (state_q != IDLE) ? V[VA_W-1:0] : '0;
        CPU_BUSY = (pend_q != NONE) || (state_q != IDLE);
    end

    // ---- request queue, read buffer, write data ----
    always_comb begin
        pend_d   = pend_q;
        op_d     = op_q;
        vd_out_d = vd_out_q;
        rdbuf_d  = rdbuf_q;
        ovr_d    = 1'b0;

        if (launch) begin
            op_d   = pend_q;
            pend_d = NONE;
        end else if (state_q == INC) begin
            op_d   = NONE;
        end

        // A request queued behind a launching one is not an overrun;
        // only a request that replaces a still-waiting one is.
        if (strb_pulse[2] || strb_pulse[1]) begin
            if ((pend_q != NONE) && !launch) begin
                ovr_d = 1'b1;
            end
            pend_d = strb_pulse[2] ? WR : RD;
        end

        if (strb_pulse[2]) begin
            vd_out_d = DB_in;
        end

        if ((state_q == STRB) && (op_q == RD)) begin
            rdbuf_d = VD_in;
        end
    end

    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            strb_prev_q <= '1;
            pend_q      <= NONE;
            op_q        <= NONE;
            vd_out_q    <= '0;
            rdbuf_q     <= '0;
            ovr_q       <= 1'b0;
        end else begin
            strb_prev_q <= strb_prev_d;
            pend_q      <= pend_d;
            op_q        <= op_d;
            vd_out_q    <= vd_out_d;
            rdbuf_q     <= rdbuf_d;
            ovr_q       <= ovr_d;
        end
    end

    assign VD_out    = vd_out_q;
    assign CPU_RDBUF = rdbuf_q;
    assign OVR       = ovr_q;

endmodule
